// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: upstream operand fields, writeback port and downstream operand handshake.
// The stage sits on the slave side; the master side belongs to the surrounding pipeline.
interface operand_fetch_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    ptr_a;
    logic [DW-1:0] const_a;
    logic          cflag_a;
    logic [4:0]    ptr_b;
    logic [DW-1:0] const_b;
    logic          cflag_b;
    logic [3:0]    dst_in;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [3:0]    dst_out;

    modport master (
        output in_valid, ptr_a, const_a, cflag_a, ptr_b, const_b, cflag_b, dst_in,
        output wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, op_a, op_b, dst_out
    );

    modport slave (
        input  in_valid, ptr_a, const_a, cflag_a, ptr_b, const_b, cflag_b, dst_in,
        input  wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, op_a, op_b, dst_out
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: owns the flop register file, resolves two operands (constant or register,
// with same-cycle writeback forwarding) into a one-deep valid/ready output register.
module operand_fetch #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 16
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    localparam int unsigned IW = 4;

    logic [DW-1:0] rf [NREG];
    logic          accept_c;
    logic [DW-1:0] rd_a_c;
    logic [DW-1:0] rd_b_c;
    logic [DW-1:0] sel_a_c;
    logic [DW-1:0] sel_b_c;
    logic          hit_a_c;
    logic          hit_b_c;
    logic          is_reg_a;
    logic          is_reg_b;
    logic [IW-1:0] src_a;
    logic [IW-1:0] src_b;
    logic          unused_c;

    // Pointer bit 4 is resolved upstream; only cflag selects the source here.
    assign unused_c = ^{bus.ptr_a[4], bus.ptr_b[4]};

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Register read with writeback forwarding, then constant/register select.
    always_comb begin
        rd_a_c  = rf[bus.ptr_a[IW-1:0]];
        rd_b_c  = rf[bus.ptr_b[IW-1:0]];
        if (bus.wr_en && (bus.wr_addr == bus.ptr_a[IW-1:0])) rd_a_c = bus.wr_data;
        if (bus.wr_en && (bus.wr_addr == bus.ptr_b[IW-1:0])) rd_b_c = bus.wr_data;
        sel_a_c = bus.cflag_a ? bus.const_a : rd_a_c;
        sel_b_c = bus.cflag_b ? bus.const_b : rd_b_c;
        hit_a_c = bus.wr_en && is_reg_a && (src_a == bus.wr_addr);
        hit_b_c = bus.wr_en && is_reg_b && (src_b == bus.wr_addr);
    end

    // Register file write port: always honoured, independent of the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (bus.wr_en) begin
            rf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Output register: load on accept, drop valid on drain, refresh register operands while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.op_a      <= '0;
            bus.op_b      <= '0;
            bus.dst_out   <= '0;
            is_reg_a      <= 1'b0;
            is_reg_b      <= 1'b0;
            src_a         <= '0;
            src_b         <= '0;
        end else if (accept_c) begin
            bus.out_valid <= 1'b1;
            bus.op_a      <= sel_a_c;
            bus.op_b      <= sel_b_c;
            bus.dst_out   <= bus.dst_in;
            is_reg_a      <= !bus.cflag_a;
            is_reg_b      <= !bus.cflag_b;
            src_a         <= bus.ptr_a[IW-1:0];
            src_b         <= bus.ptr_b[IW-1:0];
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end else if (bus.out_valid) begin
            if (hit_a_c) bus.op_a <= bus.wr_data;
            if (hit_b_c) bus.op_b <= bus.wr_data;
        end
    end
endmodule
